// File: rtl/fetch_queue_if.sv
// Bundles the instruction-memory request/response channel, the decode-side
// handshake and the execute-stage redirect of the fetch queue.
interface fetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output id_valid,
    input  id_ready,
    output id_pc,
    output id_instr,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  id_valid,
    output id_ready,
    input  id_pc,
    input  id_instr,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential word fetches under a credit
// limit, tags in-flight PCs, buffers returned words for decode, flushes on redirect.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];
  localparam logic [PW-1:0] ONE_P   = PW'(1'b1);
  localparam logic [CW-1:0] ONE_C   = CW'(1'b1);

  logic [31:0]   fetch_pc_r;
  logic [31:0]   fifo_pc_r    [DEPTH];
  logic [31:0]   fifo_instr_r [DEPTH];
  logic [31:0]   req_pc_r     [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rq_rd_r;
  logic [PW-1:0] rq_wr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] drop_r;

  logic [CW:0]   in_use_s;
  logic          credit_s;
  logic          req_valid_s;
  logic          id_valid_s;
  logic          req_fire_s;
  logic          rsp_keep_s;
  logic          rsp_drop_s;
  logic          pop_s;
  logic [CW-1:0] count_nxt_s;
  logic [CW-1:0] outst_nxt_s;
  logic [CW-1:0] owed_s;

  // Handshake qualification and next-state arithmetic for the occupancy counters.
  always_comb begin
    in_use_s    = {1'b0, count_r} + {1'b0, outstanding_r};
    credit_s    = (in_use_s < DEPTH_W);
    req_valid_s = !reset && !bus.redirect_valid && credit_s;
    id_valid_s  = (count_r != {CW{1'b0}}) && !bus.redirect_valid;
    req_fire_s  = req_valid_s && bus.imem_req_ready;
    rsp_drop_s  = bus.imem_rsp_valid && (drop_r != {CW{1'b0}});
    rsp_keep_s  = bus.imem_rsp_valid && (drop_r == {CW{1'b0}});
    pop_s       = id_valid_s && bus.id_ready;

    case ({req_fire_s, bus.imem_rsp_valid})
      2'b10:   outst_nxt_s = outstanding_r + ONE_C;
      2'b01:   outst_nxt_s = outstanding_r - ONE_C;
      default: outst_nxt_s = outstanding_r;
    endcase

    case ({rsp_keep_s, pop_s})
      2'b10:   count_nxt_s = count_r + ONE_C;
      2'b01:   count_nxt_s = count_r - ONE_C;
      default: count_nxt_s = count_r;
    endcase

    // Responses still owed after a flush: everything in flight except one landing now.
    if (bus.imem_rsp_valid) begin
      owed_s = outstanding_r - ONE_C;
    end else begin
      owed_s = outstanding_r;
    end
  end

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = fetch_pc_r;
  assign bus.id_valid       = id_valid_s;
  assign bus.id_pc          = fifo_pc_r[rd_ptr_r];
  assign bus.id_instr       = fifo_instr_r[rd_ptr_r];

  // Fetch PC, PC-tag queue, instruction FIFO and counters; redirect outranks all traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r    <= RESET_PC;
      rd_ptr_r      <= {PW{1'b0}};
      wr_ptr_r      <= {PW{1'b0}};
      rq_rd_r       <= {PW{1'b0}};
      rq_wr_r       <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
      outstanding_r <= {CW{1'b0}};
      drop_r        <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_r[i]    <= 32'h0000_0000;
        fifo_instr_r[i] <= 32'h0000_0000;
        req_pc_r[i]     <= 32'h0000_0000;
      end
    end else if (bus.redirect_valid) begin
      fetch_pc_r    <= bus.redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_r      <= {PW{1'b0}};
      wr_ptr_r      <= {PW{1'b0}};
      rq_rd_r       <= {PW{1'b0}};
      rq_wr_r       <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
      outstanding_r <= owed_s;
      drop_r        <= owed_s;
    end else begin
      if (req_fire_s) begin
        req_pc_r[rq_wr_r] <= fetch_pc_r;
        rq_wr_r           <= rq_wr_r + ONE_P;
        fetch_pc_r        <= fetch_pc_r + 32'd4;
      end
      // A kept response retires the oldest live tag into the decode FIFO.
      if (rsp_keep_s) begin
        fifo_pc_r[wr_ptr_r]    <= req_pc_r[rq_rd_r];
        fifo_instr_r[wr_ptr_r] <= bus.imem_rsp_data;
        wr_ptr_r               <= wr_ptr_r + ONE_P;
        rq_rd_r                <= rq_rd_r + ONE_P;
      end
      if (rsp_drop_s) begin
        drop_r <= drop_r - ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_P;
      end
      count_r       <= count_nxt_s;
      outstanding_r <= outst_nxt_s;
    end
  end

endmodule
